// File: rtl/wdt_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : wdt_access_ctrl_if
// Brief    : Register bus between a host and the watchdog access controller.
// Revision : 1.0 - initial release
// ============================================================================
interface wdt_access_ctrl_if;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       wr;
    logic       rd;
    logic [7:0] rdata;

    modport master (
        output addr,
        output wdata,
        output wr,
        output rd,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wdata,
        input  wr,
        input  rd,
        output rdata
    );
endinterface
`default_nettype wire

// File: rtl/wdt_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wdt_access_ctrl
// Brief    : Register front-end and write-lock sequencer for a watchdog core.
//            Define WDT_UNLOCK_TIMEOUT_EN to auto-relock after 255 idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module wdt_access_ctrl (
    input  logic             clk,
    input  logic             reset_n,
    wdt_access_ctrl_if.slave bus,
    input  logic [15:0]      wd_counter_out,
    input  logic [15:0]      wd_reload_out,
    input  logic [7:0]       wd_config_out,
    output logic [15:0]      wd_counter_in,
    output logic [15:0]      wd_reload_in,
    output logic [7:0]       wd_config_in,
    output logic [1:0]       wd_counter_write,
    output logic [1:0]       wd_reload_write,
    output logic [1:0]       wd_zero_write,
    output logic             wd_config_write
);

    localparam logic [2:0] c_ADDR_CNT_LO = 3'd0;
    localparam logic [2:0] c_ADDR_CNT_HI = 3'd1;
    localparam logic [2:0] c_ADDR_RLD_LO = 3'd2;
    localparam logic [2:0] c_ADDR_RLD_HI = 3'd3;
    localparam logic [2:0] c_ADDR_CONFIG = 3'd4;
    localparam logic [2:0] c_ADDR_KEY    = 3'd5;
    localparam logic [2:0] c_ADDR_STATUS = 3'd6;
    localparam logic [2:0] c_ADDR_RSVD   = 3'd7;
    localparam logic [7:0] c_KEY_FIRST   = 8'h55;
    localparam logic [7:0] c_KEY_SECOND  = 8'hAA;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        KEY1     = 2'd1,
        UNLOCKED = 2'd2
    } lock_state_t;

    lock_state_t r_state;
    lock_state_t w_state_wr;
    lock_state_t w_state_nxt;

    logic        w_wr_cnt;
    logic        w_wr_rld;
    logic        w_wr_cfg;
    logic        w_wr_key;
    logic        w_wr_status;
    logic        w_wr_rsvd;
    logic        w_unlocked;
    logic        w_violation;
    logic        w_timeout_evt;
    logic        w_timeout_flag;

    logic [7:0]  r_rdata;
    logic [7:0]  r_shadow;
    logic        r_violation;
    logic [15:0] r_counter_in;
    logic [15:0] r_reload_in;
    logic [7:0]  r_config_in;
    logic [1:0]  r_counter_write;
    logic [1:0]  r_reload_write;
    logic [1:0]  r_zero_write;
    logic        r_config_write;

    always_comb begin
        w_wr_cnt    = bus.wr && ((bus.addr == c_ADDR_CNT_LO) || (bus.addr == c_ADDR_CNT_HI));
        w_wr_rld    = bus.wr && ((bus.addr == c_ADDR_RLD_LO) || (bus.addr == c_ADDR_RLD_HI));
        w_wr_cfg    = bus.wr && (bus.addr == c_ADDR_CONFIG);
        w_wr_key    = bus.wr && (bus.addr == c_ADDR_KEY);
        w_wr_status = bus.wr && (bus.addr == c_ADDR_STATUS);
        w_wr_rsvd   = bus.wr && (bus.addr == c_ADDR_RSVD);
        w_unlocked  = (r_state == UNLOCKED);
        w_violation = (w_wr_rld || w_wr_cfg) && !w_unlocked;

        // Lock transitions caused by this cycle's write; timeout is applied on top.
        w_state_wr = r_state;
        case (r_state)
            LOCKED: begin
                if (w_wr_key && (bus.wdata == c_KEY_FIRST)) w_state_wr = KEY1;
            end
            KEY1: begin
                if (w_wr_key)
                    w_state_wr = (bus.wdata == c_KEY_SECOND) ? UNLOCKED : LOCKED;
                else if (bus.wr && !w_wr_rsvd)
                    w_state_wr = LOCKED;
            end
            UNLOCKED: begin
                if (w_wr_key || w_wr_cfg) w_state_wr = LOCKED;
            end
            default: w_state_wr = LOCKED;
        endcase
    end

    assign w_state_nxt = w_timeout_evt ? LOCKED : w_state_wr;

`ifdef WDT_UNLOCK_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_timeout;

    // Fires only when the state would otherwise be held for another cycle.
    assign w_timeout_evt  = (r_state != LOCKED) && (w_state_wr == r_state) &&
                            (r_tmo_cnt == 8'hFF);
    assign w_timeout_flag = r_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            if (w_state_nxt != r_state)
                r_tmo_cnt <= 8'd0;
            else if (r_state != LOCKED)
                r_tmo_cnt <= r_tmo_cnt + 8'd1;

            if (w_timeout_evt)
                r_timeout <= 1'b1;
            else if (w_wr_status && bus.wdata[3])
                r_timeout <= 1'b0;
        end
    end
`else
    assign w_timeout_evt  = 1'b0;
    assign w_timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= LOCKED;
            r_rdata         <= 8'h00;
            r_shadow        <= 8'h00;
            r_violation     <= 1'b0;
            r_counter_in    <= 16'h0000;
            r_reload_in     <= 16'h0000;
            r_config_in     <= 8'h00;
            r_counter_write <= 2'b00;
            r_reload_write  <= 2'b00;
            r_zero_write    <= 2'b00;
            r_config_write  <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_counter_write <= 2'b00;
            r_reload_write  <= 2'b00;
            r_config_write  <= 1'b0;
            r_zero_write    <= w_violation ? 2'b11 : 2'b00;

            // Odd address selects the high byte lane for both 16-bit registers.
            if (w_wr_cnt) begin
                r_counter_write <= {bus.addr[0], ~bus.addr[0]};
                r_counter_in    <= {bus.wdata, bus.wdata};
            end
            if (w_wr_rld && w_unlocked) begin
                r_reload_write <= {bus.addr[0], ~bus.addr[0]};
                r_reload_in    <= {bus.wdata, bus.wdata};
            end
            if (w_wr_cfg && w_unlocked) begin
                r_config_write <= 1'b1;
                r_config_in    <= bus.wdata;
            end

            if (w_violation)
                r_violation <= 1'b1;
            else if (w_wr_status && bus.wdata[2])
                r_violation <= 1'b0;

            if (bus.rd) begin
                case (bus.addr)
                    c_ADDR_CNT_LO: begin
                        r_rdata  <= wd_counter_out[7:0];
                        r_shadow <= wd_counter_out[15:8];
                    end
                    c_ADDR_CNT_HI: r_rdata <= r_shadow;
                    c_ADDR_RLD_LO: r_rdata <= wd_reload_out[7:0];
                    c_ADDR_RLD_HI: r_rdata <= wd_reload_out[15:8];
                    c_ADDR_CONFIG: r_rdata <= wd_config_out;
                    c_ADDR_STATUS: r_rdata <= {4'b0000, w_timeout_flag, r_violation,
                                               (r_state == UNLOCKED), (r_state == KEY1)};
                    default:       r_rdata <= 8'h00;
                endcase
            end
        end
    end

    assign bus.rdata        = r_rdata;
    assign wd_counter_in    = r_counter_in;
    assign wd_reload_in     = r_reload_in;
    assign wd_config_in     = r_config_in;
    assign wd_counter_write = r_counter_write;
    assign wd_reload_write  = r_reload_write;
    assign wd_zero_write    = r_zero_write;
    assign wd_config_write  = r_config_write;

endmodule
`default_nettype wire

// File: tb/tb_wdt_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wdt_access_ctrl
// Brief    : Self-checking bench for wdt_access_ctrl: directed scenarios plus
//            randomized traffic against a rule-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wdt_access_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    wdt_access_ctrl_if bus ();

    logic [15:0] wd_counter_out;
    logic [15:0] wd_reload_out;
    logic [7:0]  wd_config_out;
    logic [15:0] wd_counter_in;
    logic [15:0] wd_reload_in;
    logic [7:0]  wd_config_in;
    logic [1:0]  wd_counter_write;
    logic [1:0]  wd_reload_write;
    logic [1:0]  wd_zero_write;
    logic        wd_config_write;

    wdt_access_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus              (bus),
        .wd_counter_out   (wd_counter_out),
        .wd_reload_out    (wd_reload_out),
        .wd_config_out    (wd_config_out),
        .wd_counter_in    (wd_counter_in),
        .wd_reload_in     (wd_reload_in),
        .wd_config_in     (wd_config_in),
        .wd_counter_write (wd_counter_write),
        .wd_reload_write  (wd_reload_write),
        .wd_zero_write    (wd_zero_write),
        .wd_config_write  (wd_config_write)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: keys accepted so far (0 none, 1 first key, 2 unlocked)
    int          m_keys;
    int          m_age;
    bit          m_viol;
    bit          m_tmo;
    logic [7:0]  m_rdata;
    logic [7:0]  m_shadow;
    logic [15:0] m_cnt_in;
    logic [15:0] m_rld_in;
    logic [7:0]  m_cfg_in;
    logic [1:0]  e_cw;
    logic [1:0]  e_rw;
    logic [1:0]  e_zw;
    logic        e_fw;

    task automatic model_reset();
        m_keys = 0; m_age = 0; m_viol = 0; m_tmo = 0;
        m_rdata = 8'h00; m_shadow = 8'h00;
        m_cnt_in = 16'h0; m_rld_in = 16'h0; m_cfg_in = 8'h0;
        e_cw = 2'b00; e_rw = 2'b00; e_zw = 2'b00; e_fw = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] a, input logic [7:0] d, input bit w, input bit r);
        int  nk;
        bit  prot;
        bit  viol;
        bit  set_tmo;
        if (r) begin
            case (a)
                3'd0: begin m_rdata = wd_counter_out[7:0]; m_shadow = wd_counter_out[15:8]; end
                3'd1: m_rdata = m_shadow;
                3'd2: m_rdata = wd_reload_out[7:0];
                3'd3: m_rdata = wd_reload_out[15:8];
                3'd4: m_rdata = wd_config_out;
                3'd6: m_rdata = {4'b0000, m_tmo, m_viol, (m_keys == 2), (m_keys == 1)};
                default: m_rdata = 8'h00;
            endcase
        end
        e_cw = 2'b00; e_rw = 2'b00; e_zw = 2'b00; e_fw = 1'b0;
        prot = w && (a == 3'd2 || a == 3'd3 || a == 3'd4);
        viol = prot && (m_keys != 2);
        nk   = m_keys;
        if (w) begin
            if (a == 3'd0 || a == 3'd1) begin
                e_cw = (a == 3'd0) ? 2'b01 : 2'b10;
                m_cnt_in = {d, d};
            end
            if (prot && !viol) begin
                if (a == 3'd4) begin e_fw = 1'b1; m_cfg_in = d; end
                else begin e_rw = (a == 3'd2) ? 2'b01 : 2'b10; m_rld_in = {d, d}; end
            end
            if (viol) e_zw = 2'b11;
            if (a == 3'd5)
                nk = (m_keys == 0 && d == 8'h55) ? 1 : (m_keys == 1 && d == 8'hAA) ? 2 : 0;
            else if (a == 3'd4 && m_keys == 2)
                nk = 0;
            else if (m_keys == 1 && a != 3'd7)
                nk = 0;
        end
        set_tmo = 0;
`ifdef WDT_UNLOCK_TIMEOUT_EN
        if (nk == m_keys && m_keys != 0 && m_age == 255) begin nk = 0; set_tmo = 1; end
        if (nk != m_keys) m_age = 0;
        else if (m_keys != 0) m_age = m_age + 1;
`endif
        if (viol) m_viol = 1;
        else if (w && a == 3'd6 && d[2]) m_viol = 0;
        if (set_tmo) m_tmo = 1;
        else if (w && a == 3'd6 && d[3]) m_tmo = 0;
        m_keys = nk;
    endtask

    task automatic do_op(input logic [2:0] a, input logic [7:0] d, input bit w, input bit r);
        @(negedge clk);
        bus.addr = a; bus.wdata = d; bus.wr = w; bus.rd = r;
        model_step(a, d, w, r);
        @(posedge clk);
        #1;
        bus.wr = 1'b0; bus.rd = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_op(3'd7, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic unlock();
        do_op(3'd5, 8'h55, 1'b1, 1'b0);
        do_op(3'd5, 8'hAA, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.addr = 3'd0; bus.wdata = 8'h00; bus.wr = 1'b0; bus.rd = 1'b0;
        wd_counter_out = 16'hBEEF; wd_reload_out = 16'h1234; wd_config_out = 8'h5A;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (wd_counter_write !== 2'b00) begin n_err++; $display("FAIL rst_cnt_wr: got %b want 00", wd_counter_write); end
        n_vec++; if (wd_reload_write !== 2'b00) begin n_err++; $display("FAIL rst_rld_wr: got %b want 00", wd_reload_write); end
        n_vec++; if (wd_zero_write !== 2'b00) begin n_err++; $display("FAIL rst_zero_wr: got %b want 00", wd_zero_write); end
        n_vec++; if (wd_config_write !== 1'b0) begin n_err++; $display("FAIL rst_cfg_wr: got %b want 0", wd_config_write); end
        n_vec++; if (wd_counter_in !== 16'h0) begin n_err++; $display("FAIL rst_cnt_in: got %h want 0000", wd_counter_in); end
        n_vec++; if (wd_reload_in !== 16'h0) begin n_err++; $display("FAIL rst_rld_in: got %h want 0000", wd_reload_in); end
        n_vec++; if (wd_config_in !== 8'h0) begin n_err++; $display("FAIL rst_cfg_in: got %h want 00", wd_config_in); end
        n_vec++; if (bus.rdata !== 8'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 00", bus.rdata); end
        @(negedge clk);
        reset_n = 1'b1;
        do_op(3'd6, 8'h00, 1'b0, 1'b1);
        n_vec++; if (bus.rdata !== 8'h00) begin n_err++; $display("FAIL rst_status: got %h want 00", bus.rdata); end
    endtask

    task automatic test_reset_mid_unlock();
        wd_counter_out = 16'hA5C3;
        do_op(3'd0, 8'h00, 1'b0, 1'b1);
        n_vec++; if (bus.rdata !== 8'hC3) begin n_err++; $display("FAIL mid_cnt_lo: got %h want c3", bus.rdata); end
        do_op(3'd5, 8'h55, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (bus.rdata !== 8'h00) begin n_err++; $display("FAIL mid_async_rdata: got %h want 00", bus.rdata); end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        do_op(3'd5, 8'hAA, 1'b1, 1'b0);
        do_op(3'd6, 8'h00, 1'b0, 1'b1);
        n_vec++; if (bus.rdata !== 8'h00) begin n_err++; $display("FAIL mid_status: got %h want 00", bus.rdata); end
        do_op(3'd1, 8'h00, 1'b0, 1'b1);
        n_vec++; if (bus.rdata !== 8'h00) begin n_err++; $display("FAIL mid_shadow: got %h want 00", bus.rdata); end
    endtask

    task automatic test_unlock_reload();
        unlock();
        do_op(3'd3, 8'h12, 1'b1, 1'b0);
        n_vec++; if (wd_reload_write !== 2'b10) begin n_err++; $display("FAIL rld_strobe: got %b want 10", wd_reload_write); end
        n_vec++; if (wd_reload_in !== 16'h1212) begin n_err++; $display("FAIL rld_data: got %h want 1212", wd_reload_in); end
        n_vec++; if (wd_zero_write !== 2'b00) begin n_err++; $display("FAIL rld_zero: got %b want 00", wd_zero_write); end
        idle(1);
        n_vec++; if (wd_reload_write !== 2'b00) begin n_err++; $display("FAIL rld_one_cycle: got %b want 00", wd_reload_write); end
        do_op(3'd6, 8'h00, 1'b0, 1'b1);
        n_vec++; if (bus.rdata !== 8'h02) begin n_err++; $display("FAIL rld_status: got %h want 02", bus.rdata); end
    endtask

    task automatic test_config_violation();
        do_op(3'd5, 8'h00, 1'b1, 1'b0);
        do_op(3'd4, 8'h01, 1'b1, 1'b0);
        n_vec++; if (wd_config_write !== 1'b0) begin n_err++; $display("FAIL viol_cfg_wr: got %b want 0", wd_config_write); end
        n_vec++; if (wd_zero_write !== 2'b11) begin n_err++; $display("FAIL viol_zero: got %b want 11", wd_zero_write); end
        idle(1);
        n_vec++; if (wd_zero_write !== 2'b00) begin n_err++; $display("FAIL viol_zero_one_cycle: got %b want 00", wd_zero_write); end
        do_op(3'd6, 8'h00, 1'b0, 1'b1);
        n_vec++; if (bus.rdata !== 8'h04) begin n_err++; $display("FAIL viol_status: got %h want 04", bus.rdata); end
    endtask

    task automatic test_config_relock();
        do_op(3'd6, 8'h0C, 1'b1, 1'b0);
        unlock();
        do_op(3'd4, 8'h01, 1'b1, 1'b0);
        n_vec++; if (wd_config_write !== 1'b1) begin n_err++; $display("FAIL relock_cfg_wr: got %b want 1", wd_config_write); end
        n_vec++; if (wd_config_in !== 8'h01) begin n_err++; $display("FAIL relock_cfg_in: got %h want 01", wd_config_in); end
        do_op(3'd2, 8'h34, 1'b1, 1'b0);
        n_vec++; if (wd_zero_write !== 2'b11) begin n_err++; $display("FAIL relock_zero: got %b want 11", wd_zero_write); end
        n_vec++; if (wd_reload_write !== 2'b00) begin n_err++; $display("FAIL relock_rld_wr: got %b want 00", wd_reload_write); end
    endtask

    task automatic test_w1c_same_cycle();
        do_op(3'd6, 8'h04, 1'b1, 1'b1);
        n_vec++; if (bus.rdata !== 8'h04) begin n_err++; $display("FAIL w1c_pre: got %h want 04", bus.rdata); end
        do_op(3'd6, 8'h00, 1'b0, 1'b1);
        n_vec++; if (bus.rdata !== 8'h00) begin n_err++; $display("FAIL w1c_post: got %h want 00", bus.rdata); end
    endtask

    task automatic test_coherent_read();
        wd_counter_out = 16'h12FF;
        do_op(3'd0, 8'h00, 1'b0, 1'b1);
        n_vec++; if (bus.rdata !== 8'hFF) begin n_err++; $display("FAIL coh_lo: got %h want ff", bus.rdata); end
        wd_counter_out = 16'h1300;
        do_op(3'd1, 8'h00, 1'b0, 1'b1);
        n_vec++; if (bus.rdata !== 8'h12) begin n_err++; $display("FAIL coh_hi: got %h want 12", bus.rdata); end
        do_op(3'd1, 8'h7E, 1'b1, 1'b0);
        n_vec++; if (wd_counter_write !== 2'b10) begin n_err++; $display("FAIL kick_strobe: got %b want 10", wd_counter_write); end
        n_vec++; if (wd_counter_in !== 16'h7E7E) begin n_err++; $display("FAIL kick_data: got %h want 7e7e", wd_counter_in); end
        n_vec++; if (bus.rdata !== 8'h12) begin n_err++; $display("FAIL rdata_hold: got %h want 12", bus.rdata); end
    endtask

    task automatic test_bad_key();
        do_op(3'd5, 8'h55, 1'b1, 1'b0);
        do_op(3'd5, 8'h33, 1'b1, 1'b0);
        do_op(3'd6, 8'h00, 1'b0, 1'b1);
        n_vec++; if (bus.rdata !== 8'h00) begin n_err++; $display("FAIL badkey_status: got %h want 00", bus.rdata); end
        do_op(3'd5, 8'hAA, 1'b1, 1'b0);
        do_op(3'd6, 8'h00, 1'b0, 1'b1);
        n_vec++; if (bus.rdata !== 8'h00) begin n_err++; $display("FAIL aa_alone_status: got %h want 00", bus.rdata); end
    endtask

    task automatic test_timeout();
        do_op(3'd6, 8'h0C, 1'b1, 1'b0);
        unlock();
        idle(200);
        do_op(3'd6, 8'h00, 1'b0, 1'b1);
        n_vec++; if (bus.rdata !== 8'h02) begin n_err++; $display("FAIL tmo_early: got %h want 02", bus.rdata); end
        idle(100);
        do_op(3'd6, 8'h00, 1'b0, 1'b1);
`ifdef WDT_UNLOCK_TIMEOUT_EN
        n_vec++; if (bus.rdata !== 8'h08) begin n_err++; $display("FAIL tmo_expired: got %h want 08", bus.rdata); end
`else
        n_vec++; if (bus.rdata !== 8'h02) begin n_err++; $display("FAIL tmo_held: got %h want 02", bus.rdata); end
`endif
    endtask

    task automatic test_random();
        logic [2:0] a;
        logic [7:0] d;
        bit         w;
        bit         r;
        for (int i = 0; i < 600; i++) begin
            a = 3'($urandom_range(0, 7));
            d = 8'($urandom);
            if (a == 3'd5 && $urandom_range(0, 9) < 8) d = ($urandom_range(0, 1) == 0) ? 8'h55 : 8'hAA;
            w = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 1) != 0);
            wd_counter_out = 16'($urandom);
            wd_reload_out  = 16'($urandom);
            wd_config_out  = 8'($urandom);
            do_op(a, d, w, r);
            n_vec++; if (bus.rdata !== m_rdata) begin n_err++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, bus.rdata, m_rdata); end
            n_vec++; if (wd_counter_write !== e_cw) begin n_err++; $display("FAIL rnd_cnt_wr[%0d]: got %b want %b", i, wd_counter_write, e_cw); end
            n_vec++; if (wd_reload_write !== e_rw) begin n_err++; $display("FAIL rnd_rld_wr[%0d]: got %b want %b", i, wd_reload_write, e_rw); end
            n_vec++; if (wd_zero_write !== e_zw) begin n_err++; $display("FAIL rnd_zero_wr[%0d]: got %b want %b", i, wd_zero_write, e_zw); end
            n_vec++; if (wd_config_write !== e_fw) begin n_err++; $display("FAIL rnd_cfg_wr[%0d]: got %b want %b", i, wd_config_write, e_fw); end
            n_vec++; if (wd_counter_in !== m_cnt_in) begin n_err++; $display("FAIL rnd_cnt_in[%0d]: got %h want %h", i, wd_counter_in, m_cnt_in); end
            n_vec++; if (wd_reload_in !== m_rld_in) begin n_err++; $display("FAIL rnd_rld_in[%0d]: got %h want %h", i, wd_reload_in, m_rld_in); end
            n_vec++; if (wd_config_in !== m_cfg_in) begin n_err++; $display("FAIL rnd_cfg_in[%0d]: got %h want %h", i, wd_config_in, m_cfg_in); end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_unlock();
        test_unlock_reload();
        test_config_violation();
        test_config_relock();
        test_w1c_same_cycle();
        test_coherent_read();
        test_bad_key();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wdt_access_ctrl.md
WDT_ACCESS_CTRL -- requirements
Module: wdt_access_ctrl

Interface
REQ-001 SHALL: clk  input  1  system clock; all state on rising edge.
REQ-002 SHALL: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: addr  input  3  register select: 0 cnt_lo, 1 cnt_hi, 2 rld_lo, 3 rld_hi, 4 config, 5 key, 6 status, 7 reserved.
REQ-004 SHALL: wdata  input  8  bus write data.
REQ-005 SHALL: wr / rd  input  1 each  single-cycle write / read strobes.
REQ-006 SHALL: rdata  output  8  read data, registered.
REQ-007 SHALL: wd_counter_out, wd_reload_out  input  16 each; wd_config_out  input  8  watchdog register values.
REQ-008 SHALL: wd_counter_in, wd_reload_in  output  16 each; wd_config_in  output  8  write data to watchdog.
REQ-009 SHALL: wd_counter_write, wd_reload_write, wd_zero_write  output  2 each; wd_config_write  output  1  byte-lane write strobes to watchdog.

Function
REQ-010 SHALL: all wd_* strobes and wd_*_in data registered; strobe asserted exactly one cycle, in the cycle after the accepting wr.
REQ-011 SHALL: write data replicated on both bytes of 16-bit wd_*_in; byte lane chosen by strobe bit (lo = bit0, hi = bit1).
REQ-012 SHALL: cnt_lo/cnt_hi writes (kick) always accepted, independent of lock state.
REQ-013 SHALL: lock FSM states LOCKED, KEY1, UNLOCKED; reset state LOCKED.
REQ-014 SHALL: key write 0x55 in LOCKED -> KEY1; key write 0xAA in KEY1 -> UNLOCKED; any other key write in LOCKED/KEY1 -> LOCKED.
REQ-015 SHALL: any non-key write in KEY1 -> LOCKED; that write then handled per current lock rules (protected write = violation).
REQ-016 SHALL: in UNLOCKED, rld_lo/rld_hi writes accepted, state retained; config write accepted and -> LOCKED; key write any value -> LOCKED.
REQ-017 SHALL: rld_lo/rld_hi/config write while not UNLOCKED = violation: write discarded, wd_zero_write = 2'b11 for one cycle, status.violation set.
REQ-018 SHALL: status read = {4'b0, timeout, violation, unlocked, key1}; status write of 1 to bit2/bit3 clears violation/timeout (W1C); status write never a violation.
REQ-019 SHALL: rd of cnt_lo returns wd_counter_out[7:0] and latches wd_counter_out[15:8] into shadow; rd of cnt_hi returns shadow (coherent 16-bit read).
REQ-020 SHALL: rd of rld_lo/rld_hi/config returns watchdog value; rd of key/reserved returns 0x00; rdata valid the cycle after rd, held until next rd.
REQ-021 SHALL: wr and rd in same cycle: both performed; write effect on watchdog not visible in that read.
REQ-022 SHALL: writes to reserved address ignored, no state change.
REQ-023 SHALL: violation and new set in same cycle as W1C clear: set wins.

Reset
REQ-024 SHALL: while reset_n low: FSM LOCKED, all strobes 0, wd_*_in 0, rdata 0x00, shadow 0x00, violation/timeout 0, timeout counter 0.
REQ-025 SHALL: reset mid-unlock sequence discards progress; first cycle after release is LOCKED.

Configuration
REQ-026 SHALL: macro WDT_UNLOCK_TIMEOUT_EN defined: 8-bit counter cleared on entry to KEY1/UNLOCKED, increments each cycle there; at 255 without leaving state -> LOCKED, status.timeout set.
REQ-027 SHALL: macro undefined: no timeout counter; KEY1/UNLOCKED held indefinitely; status.timeout reads 0.

Verification
REQ-028 SHALL: key 0x55, key 0xAA, wr rld_hi 0x12 -> wd_reload_write=2'b10, wd_reload_in=0x1212 next cycle; status.unlocked=1.
REQ-029 SHALL: from LOCKED wr config 0x01 -> no wd_config_write; wd_zero_write=2'b11 one cycle; status=0x04.
REQ-030 SHALL: unlock, wr config 0x01 -> wd_config_write=1, wd_config_in=0x01; following wr rld_lo -> violation.
REQ-031 SHALL: wd_counter_out=0x12FF, rd cnt_lo; counter changes to 0x1300; rd cnt_hi -> rdata 0xFF then 0x12.
REQ-032 SHALL: key 0x55 then key 0x33 -> LOCKED; key 0xAA alone -> stays LOCKED.
REQ-033 SHALL: with WDT_UNLOCK_TIMEOUT_EN, unlock then 255 idle cycles -> LOCKED, status.timeout=1; without macro, still UNLOCKED.
